fifo_ptr_ctrl: RTL and testbench

- Parametrised gray-code pointer controller for one side of an asynchronous FIFO: the write side in enqueue mode, the read side in dequeue mode.
- Owns the local binary/gray pointer and a built-in multi-stage synchroniser for the opposite domain's gray pointer.
- Produces full/empty, a programmable almost-full/almost-empty flag, an occupancy level and a sticky overflow/underflow error.
- Replaces the bare pointer/status counter in the FIFO wrapper; two instances (MODE 0 and MODE 1) plus a dual-port RAM form the complete FIFO.

---
 rtl/fifo_ptr_ctrl.sv | 92 +++++++++
 tb/tb_fifo_ptr_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fifo_ptr_ctrl.sv
// Gray-code pointer controller for one side of an asynchronous FIFO.
// MODE 0 drives the write side (full), MODE 1 the read side (empty).
module fifo_ptr_ctrl #(
  parameter int unsigned ADDRW       = 8,
  parameter int unsigned MODE        = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic [ADDRW:0]   oppclockptr,
  input  logic [ADDRW:0]   thresh,
  output logic [ADDRW:0]   pointer,
  output logic [ADDRW-1:0] addr,
  output logic             accept,
  output logic             status,
  output logic             almost,
  output logic [ADDRW:0]   level,
  output logic             err
);

  localparam bit             ENQ   = (MODE == 0);
  localparam logic [ADDRW:0] DEPTH = {1'b1, {ADDRW{1'b0}}};
  localparam logic [ADDRW:0] ONE   = {{ADDRW{1'b0}}, 1'b1};

  logic [ADDRW:0]                  bin_q;
  logic [ADDRW:0]                  gray_q;
  logic [ADDRW:0]                  bin_nxt;
  logic [ADDRW:0]                  gray_nxt;
  logic [SYNC_STAGES-1:0][ADDRW:0] sync_q;
  logic [ADDRW:0]                  oppgray;
  logic [ADDRW:0]                  oppbin;
  logic                            err_q;

  assign bin_nxt  = bin_q + ONE;
  assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

  // Gray is registered next to binary so the cross-domain pointer never glitches.
  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else if (accept) begin
      bin_q  <= bin_nxt;
      gray_q <= gray_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], oppclockptr};
    end
  end

  assign oppgray = sync_q[SYNC_STAGES-1];

  for (genvar g = 0; g <= ADDRW; g++) begin : g_gray2bin
    assign oppbin[g] = ^oppgray[ADDRW:g];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (inc && status) begin
      err_q <= 1'b1;
    end
  end

  // Modulo subtraction keeps the occupancy correct across pointer wrap.
  always_comb begin
    level  = '0;
    status = 1'b0;
    almost = 1'b0;
    if (ENQ) begin
      level  = bin_q - oppbin;
      status = (level == DEPTH);
      almost = (level >= thresh);
    end else begin
      level  = oppbin - bin_q;
      status = (level == '0);
      almost = (level <= thresh);
    end
  end

  assign accept  = inc && !status;
  assign pointer = gray_q;
  assign addr    = bin_q[ADDRW-1:0];
  assign err     = err_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl: one enqueue and one dequeue instance,
// ADDRW=3, SYNC_STAGES=2, thresh=6, directed vectors with hand-computed results.
module tb_fifo_ptr_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       inc0, inc1;
  logic [3:0] opp0, opp1;
  logic [3:0] thresh;
  logic [3:0] ptr0, ptr1, lvl0, lvl1;
  logic [2:0] addr0, addr1;
  logic       acc0, acc1, st0, st1, alm0, alm1, err0, err1;

  always #5 clock = ~clock;

  fifo_ptr_ctrl #(.ADDRW(3), .MODE(0), .SYNC_STAGES(2)) u_enq (
    .clock(clock), .reset(reset), .inc(inc0), .oppclockptr(opp0), .thresh(thresh),
    .pointer(ptr0), .addr(addr0), .accept(acc0), .status(st0), .almost(alm0),
    .level(lvl0), .err(err0)
  );

  fifo_ptr_ctrl #(.ADDRW(3), .MODE(1), .SYNC_STAGES(2)) u_deq (
    .clock(clock), .reset(reset), .inc(inc1), .oppclockptr(opp1), .thresh(thresh),
    .pointer(ptr1), .addr(addr1), .accept(acc1), .status(st1), .almost(alm1),
    .level(lvl1), .err(err1)
  );

  // gray(0..15), written out by hand
  logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                            4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                            4'b1010, 4'b1011, 4'b1001, 4'b1000};

  typedef struct {
    int    dut;
    string nm;
    int    ptr, adr, lvl, st, alm, acc, er;   // -1 = not checked
  } exp_t;

  exp_t sbq[$];
  int   npass = 0;
  int   ntotal = 0;
  bit   run = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    ntotal++;
    if (act == req) npass++;
    else $display("FAIL %s: got %0d, required %0d", nm, act, req);
  endtask

  function automatic void ex(input int dut, input string nm, input int ptr, input int adr,
                             input int lvl, input int st, input int alm, input int acc,
                             input int er);
    exp_t e;
    e.dut = dut; e.nm = nm; e.ptr = ptr; e.adr = adr; e.lvl = lvl;
    e.st = st; e.alm = alm; e.acc = acc; e.er = er;
    sbq.push_back(e);
  endfunction

  // Monitor: drains every expectation queued for this cycle at the falling edge.
  always @(negedge clock) begin
    exp_t e;
    int a_ptr, a_adr, a_lvl, a_st, a_alm, a_acc, a_er;
    while (sbq.size() != 0) begin
      e = sbq.pop_front();
      if (e.dut == 0) begin
        a_ptr = int'(ptr0); a_adr = int'(addr0); a_lvl = int'(lvl0); a_st = int'(st0);
        a_alm = int'(alm0); a_acc = int'(acc0); a_er = int'(err0);
      end else begin
        a_ptr = int'(ptr1); a_adr = int'(addr1); a_lvl = int'(lvl1); a_st = int'(st1);
        a_alm = int'(alm1); a_acc = int'(acc1); a_er = int'(err1);
      end
      if (e.ptr >= 0) chk({e.nm, ".pointer"}, a_ptr, e.ptr);
      if (e.adr >= 0) chk({e.nm, ".addr"},    a_adr, e.adr);
      if (e.lvl >= 0) chk({e.nm, ".level"},   a_lvl, e.lvl);
      if (e.st  >= 0) chk({e.nm, ".status"},  a_st,  e.st);
      if (e.alm >= 0) chk({e.nm, ".almost"},  a_alm, e.alm);
      if (e.acc >= 0) chk({e.nm, ".accept"},  a_acc, e.acc);
      if (e.er  >= 0) chk({e.nm, ".err"},     a_er,  e.er);
    end
    if (run) begin
      chk("bound0.level_le_8", int'(lvl0 <= 4'd8), 1);
      chk("bound1.level_le_8", int'(lvl1 <= 4'd8), 1);
    end
  end

  task automatic apply(input logic r, input logic i0, input logic i1);
    @(posedge clock);
    #1;
    reset = r;
    inc0  = i0;
    inc1  = i1;
  endtask

  initial begin
    int b;
    reset = 1'b1; inc0 = 1'b0; inc1 = 1'b0; opp0 = '0; opp1 = '0; thresh = 4'd6;

    repeat (3) apply(1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0);
    ex(0, "rst0", 0, 0, 0, 0, 0, 0, 0);
    ex(1, "rst1", 0, 0, 0, 1, 1, 0, 0);
    run = 1'b1;

    // enqueue fill with the read pointer held at 0
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b1, 1'b0);
      ex(0, "fill", int'(gtab[k]), k, k, 0, int'(k >= 6), 1, 0);
    end
    apply(1'b0, 1'b1, 1'b0);
    ex(0, "full_inc", 4'b1100, 0, 8, 1, 1, 0, 0);
    apply(1'b0, 1'b0, 1'b0);
    ex(0, "ovf_err", 4'b1100, 0, 8, 1, 1, 0, 1);
    apply(1'b0, 1'b0, 1'b0);
    ex(0, "ovf_sticky", -1, -1, -1, -1, -1, -1, 1);

    // read pointer jumps to gray(3); visible only after two local edges
    apply(1'b0, 1'b0, 1'b0); opp0 = 4'b0010;
    ex(0, "drain_e0", -1, -1, 8, 1, -1, -1, -1);
    apply(1'b0, 1'b0, 1'b0);
    ex(0, "drain_e1", -1, -1, 8, 1, -1, -1, -1);
    apply(1'b0, 1'b0, 1'b0);
    ex(0, "drain_e2", 4'b1100, 0, 5, 0, 0, 0, 1);

    // dequeue side: walk bin to 12 with the write pointer kept ahead
    apply(1'b0, 1'b0, 1'b0); opp1 = 4'b1100;
    apply(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      apply(1'b0, 1'b0, 1'b1);
      if (k == 0) ex(1, "pre_l8", 0, 0, 8, 0, 0, 1, 0);
    end
    apply(1'b0, 1'b0, 1'b0); opp1 = 4'b1010;
    ex(1, "pre_l0", 4'b1100, 0, 0, 1, 1, 0, 0);
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b1);
    ex(1, "pre_l4", 4'b1100, 0, 4, 0, 1, 1, 0);
    repeat (3) apply(1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b0); opp1 = 4'b0110;
    ex(1, "pre_b12", 4'b1010, 4, 0, 1, 1, 0, 0);
    apply(1'b0, 1'b0, 1'b0);

    // wrap: write pointer at 20 mod 16, reads from bin 12 through 15 into 0..4
    for (int k = 0; k <= 8; k++) begin
      apply(1'b0, 1'b0, logic'(k < 8));
      b = (12 + k) % 16;
      ex(1, "wrap", int'(gtab[b]), b % 8, 8 - k, int'(k == 8), int'((8 - k) <= 6),
         int'(k < 8), 0);
    end
    apply(1'b0, 1'b0, 1'b1);
    ex(1, "unf_inc", 4'b0110, 4, 0, 1, 1, 0, 0);
    apply(1'b0, 1'b0, 1'b0);
    ex(1, "unf_err", 4'b0110, 4, 0, 1, 1, 0, 1);

    // reset wins over a concurrent inc
    apply(1'b1, 1'b1, 1'b0);
    ex(0, "rst_inc", 4'b1100, 0, 5, 0, 0, 1, 1);
    apply(1'b0, 1'b0, 1'b0); opp0 = '0; opp1 = '0;
    ex(0, "post_rst0", 0, 0, 0, 0, 0, 0, 0);
    ex(1, "post_rst1", 0, 0, 0, 1, 1, 0, 0);

    @(negedge clock);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
